// File: rtl/prod_accumulator.sv
// prod_accumulator: sums N_TERMS unsigned 16-bit products into a saturating ACC_W-bit result
// with valid/ready handshakes on both the product input and the result output.
module prod_accumulator #(
   parameter int N_TERMS = 8,
   parameter int ACC_W   = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] sum,
   output logic             ovf,
   output logic             busy,
   output logic [7:0]       cnt
);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
   state_t           state_q, state_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [ACC_W:0]   add;
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      // one guard bit catches the carry that triggers saturation
      add     = {1'b0, sum_q} + {{(ACC_W-15){1'b0}}, prod};
      case (state_q)
         IDLE: if (start) begin
            state_d = ACC;
            sum_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
         end
         ACC: if (in_valid) begin
            sum_d = add[ACC_W] ? '1 : add[ACC_W-1:0];
            ovf_d = ovf_q | add[ACC_W];
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(N_TERMS - 1)) state_d = DONE;
         end
         DONE: if (out_ready) begin
            state_d = start ? ACC : IDLE;
            if (start) begin
               sum_d = '0;
               ovf_d = 1'b0;
               cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end
   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign ovf       = ovf_q;
   assign cnt       = cnt_q;
endmodule

// File: tb/tb_prod_accumulator.sv
// tb_prod_accumulator: table vectors, hand-written corner sequences and random runs against
// an arithmetic reference (plain sum, clipped at 2^W-1) for default and ACC_W=16/N_TERMS=2 DUTs.
module tb_prod_accumulator;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start0, in_valid0, in_ready0, out_valid0, out_ready0, ovf0, busy0;
   logic [15:0] prod0;
   logic [18:0] sum0;
   logic [7:0]  cnt0;
   logic        start1, in_valid1, in_ready1, out_valid1, out_ready1, ovf1, busy1;
   logic [15:0] prod1;
   logic [15:0] sum1;
   logic [7:0]  cnt1;
   int          n_cmp = 0;
   int          n_fail = 0;
   int unsigned pv[8];
   typedef struct {
      int unsigned p[8];
      int unsigned exp_sum;
      bit          exp_ovf;
      int          gap;
   } vec_t;
   vec_t tbl[5];
   always #5 clk = ~clk;
   prod_accumulator u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid0), .in_ready(in_ready0),
      .prod(prod0), .out_valid(out_valid0), .out_ready(out_ready0), .sum(sum0), .ovf(ovf0),
      .busy(busy0), .cnt(cnt0)
   );
   prod_accumulator #(.N_TERMS(2), .ACC_W(16)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
      .prod(prod1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .ovf(ovf1),
      .busy(busy1), .cnt(cnt1)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [63:0] model(input int n, input int w, output bit o);
      longint s = 0;
      longint mx = (longint'(1) << w) - 1;
      for (int i = 0; i < n; i++) s += longint'(pv[i]);
      o = (s > mx);
      return o ? 64'(mx) : 64'(s);
   endfunction
   task automatic run0(input int n, input int gap, input int start_at, input bit skip_start,
                       input bit pop, input int hold, input logic [63:0] esum, input bit eovf);
      int k = 0;
      int edges = 1;
      bit iv, ir;
      if (!skip_start) begin
         start0 = 1'b1;
         tick();
         start0 = 1'b0;
         chk("start_sum", sum0, 0);
         chk("start_cnt", cnt0, 0);
         chk("start_busy", busy0, 1);
         chk("start_in_ready", in_ready0, 1);
      end
      while (!out_valid0 && edges < 200) begin
         iv = (gap == 0) || (edges % 2 == 0);
         ir = in_ready0;
         in_valid0 = iv;
         prod0 = (iv && k < 8) ? 16'(pv[k]) : 16'($urandom);
         start0 = (k == start_at);
         tick();
         edges++;
         if (iv && ir) k++;
      end
      in_valid0 = 1'b0;
      start0 = 1'b0;
      chk("out_valid", out_valid0, 1);
      chk("latency", edges, (gap != 0) ? 2 * n + 1 : n + 1);
      chk("sum", sum0, esum);
      chk("ovf", ovf0, eovf);
      chk("cnt", cnt0, n);
      chk("done_in_ready", in_ready0, 0);
      out_ready0 = 1'b0;
      for (int h = 0; h < hold; h++) begin
         start0 = (h % 2 == 0);
         tick();
         chk("hold_valid", out_valid0, 1);
         chk("hold_sum", sum0, esum);
         chk("hold_in_ready", in_ready0, 0);
      end
      start0 = 1'b0;
      if (pop) begin
         out_ready0 = 1'b1;
         tick();
         out_ready0 = 1'b0;
         chk("pop_valid", out_valid0, 0);
         chk("pop_busy", busy0, 0);
      end
   endtask
   task automatic run1(input logic [63:0] esum, input bit eovf);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("u1_start_sum", sum1, 0);
      chk("u1_start_ovf", ovf1, 0);
      in_valid1 = 1'b1;
      for (int k = 0; k < 2; k++) begin
         prod1 = 16'(pv[k]);
         tick();
      end
      in_valid1 = 1'b0;
      chk("u1_out_valid", out_valid1, 1);
      chk("u1_sum", sum1, esum);
      chk("u1_ovf", ovf1, eovf);
      chk("u1_cnt", cnt1, 2);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      chk("u1_pop_busy", busy1, 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      logic [63:0] e;
      bit o;
      tbl[0] = '{p: '{1, 2, 3, 4, 5, 6, 7, 8}, exp_sum: 36, exp_ovf: 0, gap: 0};
      tbl[1] = '{p: '{8{65025}}, exp_sum: 520200, exp_ovf: 0, gap: 0};
      tbl[2] = '{p: '{1, 2, 3, 4, 5, 6, 7, 8}, exp_sum: 36, exp_ovf: 0, gap: 1};
      tbl[3] = '{p: '{8{0}}, exp_sum: 0, exp_ovf: 0, gap: 0};
      tbl[4] = '{p: '{8{65535}}, exp_sum: 524280, exp_ovf: 0, gap: 1};
      rst_n = 1'b0;
      {start0, in_valid0, out_ready0, start1, in_valid1, out_ready1} = '0;
      prod0 = '0;
      prod1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready0, 0);
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_sum", sum0, 0);
      chk("rst_cnt", cnt0, 0);
      chk("rst_ovf", ovf0, 0);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         pv = tbl[i].p;
         run0(8, tbl[i].gap, -1, 0, 1, 2, tbl[i].exp_sum, tbl[i].exp_ovf);
      end
      // back-pressure then same-cycle pop and restart
      pv = '{1, 2, 3, 4, 5, 6, 7, 8};
      run0(8, 0, -1, 0, 0, 5, 36, 0);
      out_ready0 = 1'b1;
      start0 = 1'b1;
      tick();
      out_ready0 = 1'b0;
      start0 = 1'b0;
      chk("restart_in_ready", in_ready0, 1);
      chk("restart_valid", out_valid0, 0);
      chk("restart_sum", sum0, 0);
      chk("restart_cnt", cnt0, 0);
      run0(8, 0, -1, 1, 1, 0, 36, 0);
      // start while accumulating must be ignored
      pv = '{8{10}};
      run0(8, 0, 3, 0, 1, 0, 80, 0);
      // reset after four transfers
      pv = '{8{10}};
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      in_valid0 = 1'b1;
      prod0 = 16'd10;
      repeat (4) tick();
      chk("pre_rst_sum", sum0, 40);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_sum", sum0, 0);
      chk("async_rst_busy", busy0, 0);
      chk("async_rst_cnt", cnt0, 0);
      chk("async_rst_in_ready", in_ready0, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post_rst_valid", out_valid0, 0);
         chk("post_rst_busy", busy0, 0);
      end
      in_valid0 = 1'b0;
      // saturating narrow instance
      pv[0] = 65025;
      pv[1] = 65025;
      run1(65535, 1);
      pv[0] = 1;
      pv[1] = 1;
      run1(2, 0);
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 8; i++) pv[i] = $urandom_range(0, 65535);
         e = model(2, 16, o);
         run1(e, o);
         e = model(8, 19, o);
         run0(8, int'($urandom_range(0, 1)), -1, 0, 1, int'($urandom_range(0, 3)), e, o);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
